// File: rtl/dstack_pkg.sv
// Shared types for the data stack: movement encodings
// and the per-entry next-value selector.
package dstack_pkg;

    typedef enum logic [1:0] {
        S_NOTHING   = 2'b00,
        S_PUSH_ONCE = 2'b01,
        S_POP_ONCE  = 2'b10,
        S_POP_TWICE = 2'b11
    } movement_t;

    // Source for a storage entry on the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_UP   = 2'b01,
        SEL_DN1  = 2'b10,
        SEL_DN2  = 2'b11
    } sel_t;

endpackage

// File: rtl/dstack_cell.sv
// One storage entry below top: a register with a
// four-way next-value mux (hold, d-1, d+1, d+2).
module dstack_cell
    import dstack_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit HAS_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  sel_t             sel,
    input  logic [WIDTH-1:0] from_up,
    input  logic [WIDTH-1:0] from_dn1,
    input  logic [WIDTH-1:0] from_dn2,
    output logic [WIDTH-1:0] value
);

    // Visible entries clear on reset; deeper ones just follow sel.
    always_ff @(posedge clk) begin
        if (HAS_RESET && !reset) begin
            value <= '0;
        end else begin
            unique case (sel)
                SEL_HOLD: value <= value;
                SEL_UP:   value <= from_up;
                SEL_DN1:  value <= from_dn1;
                SEL_DN2:  value <= from_dn2;
            endcase
        end
    end

endmodule

// File: rtl/dstack.sv
// Data stack with registered top, rotate/copy read port
// and saturating occupancy counter.
module dstack
    import dstack_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 65,
    parameter int DEPTH_MAG = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           movement,
    input  logic [WIDTH-1:0]     new_top,
    input  logic                 rotate,
    input  logic [DEPTH_MAG-2:0] rot_addr,
    output logic [WIDTH-1:0]     rot_val,
    output logic [WIDTH-1:0]     top,
    output logic [WIDTH-1:0]     second,
    output logic [WIDTH-1:0]     third,
    output logic                 overflow
);

    movement_t            mv;
    logic                 do_rot;
    logic [WIDTH-1:0]     stk [DEPTH];
    logic [WIDTH-1:0]     top_q;
    logic [DEPTH_MAG-1:0] count;

    assign mv     = movement_t'(movement);
    assign do_rot = rotate && (mv == S_NOTHING);

    // Top is rewritten every cycle regardless of movement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            top_q <= '0;
        end else begin
            top_q <= new_top;
        end
    end

    assign stk[0] = top_q;

    for (genvar d = 1; d < DEPTH; d++) begin : g_cell
        localparam int D1 = (d + 1 < DEPTH) ? d + 1 : d;
        localparam int D2 = (d + 2 < DEPTH) ? d + 2 : d;

        sel_t             sel;
        logic [WIDTH-1:0] cell_q;

        // Rotate shifts depths 1..k+1 down from their
        // shallower neighbour, overwriting the picked one.
        always_comb begin
            sel = SEL_HOLD;
            if (reset) begin
                unique case (mv)
                    S_PUSH_ONCE: sel = SEL_UP;
                    S_POP_ONCE:  sel = SEL_DN1;
                    S_POP_TWICE: sel = SEL_DN2;
                    S_NOTHING: begin
                        if (do_rot && d <= int'(rot_addr) + 1) begin
                            sel = SEL_UP;
                        end
                    end
                endcase
            end
        end

        dstack_cell #(
            .WIDTH     (WIDTH),
            .HAS_RESET (d <= 2)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .sel      (sel),
            .from_up  (stk[d-1]),
            .from_dn1 (stk[D1]),
            .from_dn2 (stk[D2]),
            .value    (cell_q)
        );

        assign stk[d] = cell_q;
    end

    // Occupancy saturates at DEPTH on push and at 0 on pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else begin
            unique case (mv)
                S_PUSH_ONCE: begin
                    if (int'(count) < DEPTH) begin
                        count <= count + DEPTH_MAG'(1);
                    end
                end
                S_POP_ONCE: begin
                    if (count != '0) begin
                        count <= count - DEPTH_MAG'(1);
                    end
                end
                S_POP_TWICE: begin
                    if (count >= DEPTH_MAG'(2)) begin
                        count <= count - DEPTH_MAG'(2);
                    end else begin
                        count <= '0;
                    end
                end
                S_NOTHING: count <= count;
            endcase
        end
    end

    // Read port: rot_addr k selects depth k+1.
    always_comb begin
        rot_val = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (int'(rot_addr) + 1 == i) begin
                rot_val = stk[i];
            end
        end
    end

    assign top      = stk[0];
    assign second   = stk[1];
    assign third    = stk[2];
    assign overflow = (int'(count) >= DEPTH - 1);

endmodule

// File: tb/tb_dstack.sv
// Randomised bench for dstack against a queue model,
// plus directed walk-throughs of the usage scenarios.
module tb_dstack;
    import dstack_pkg::*;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 65;
    localparam int DEPTH_MAG = 7;
    localparam int AW        = DEPTH_MAG - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       movement;
    logic [WIDTH-1:0] new_top;
    logic             rotate;
    logic [AW-1:0]    rot_addr;
    logic [WIDTH-1:0] rot_val;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic [WIDTH-1:0] third;
    logic             overflow;

    dstack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .DEPTH_MAG (DEPTH_MAG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .movement (movement),
        .new_top  (new_top),
        .rotate   (rotate),
        .rot_addr (rot_addr),
        .rot_val  (rot_val),
        .top      (top),
        .second   (second),
        .third    (third),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        bit               v;
    } ent_t;

    ent_t m[$];
    int   m_cnt;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag,
                            input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m = {};
        for (int i = 0; i < DEPTH; i++) begin
            m.push_back('{d: '0, v: (i < 3)});
        end
        m_cnt = 0;
    endfunction

    function automatic void model_step(input logic [1:0] mv,
                                       input logic [WIDTH-1:0] nt,
                                       input logic rot,
                                       input int k);
        ent_t blank;
        ent_t tmp;
        blank = '{d: '0, v: 1'b0};
        case (mv)
            2'b01: begin
                m.push_front('{d: nt, v: 1'b1});
                tmp = m.pop_back();
                if (m_cnt < DEPTH) m_cnt++;
            end
            2'b10: begin
                m.delete(1);
                m.push_back(blank);
                m[0] = '{d: nt, v: 1'b1};
                if (m_cnt > 0) m_cnt--;
            end
            2'b11: begin
                m.delete(1);
                m.delete(1);
                m.push_back(blank);
                m.push_back(blank);
                m[0] = '{d: nt, v: 1'b1};
                m_cnt = (m_cnt >= 2) ? m_cnt - 2 : 0;
            end
            default: begin
                if (rot) begin
                    m.delete(k + 1);
                    m.push_front('{d: nt, v: 1'b1});
                end else begin
                    m[0] = '{d: nt, v: 1'b1};
                end
            end
        endcase
    endfunction

    function automatic bit rot_known(input int k);
        return (k < m_cnt) && (k + 1 < DEPTH) && m[k+1].v;
    endfunction

    task automatic check_state();
        if (m[0].v) check_eq("top", top, m[0].d);
        if (m[1].v) check_eq("second", second, m[1].d);
        if (m[2].v) check_eq("third", third, m[2].d);
        check_eq("overflow", WIDTH'(overflow),
                 WIDTH'(m_cnt >= DEPTH - 1));
    endtask

    task automatic step(input logic [1:0] mv,
                        input logic [WIDTH-1:0] nt,
                        input logic rot,
                        input int k);
        movement = mv;
        new_top  = nt;
        rotate   = rot;
        rot_addr = AW'(k);
        #1;
        if (rot_known(k)) check_eq("rot_val", rot_val, m[k+1].d);
        @(posedge clk);
        model_step(mv, nt, rot, k);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        movement = 2'($urandom);
        rotate   = 1'($urandom);
        new_top  = $urandom;
        rot_addr = AW'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b1;
        check_eq("rst_top", top, '0);
        check_eq("rst_second", second, '0);
        check_eq("rst_third", third, '0);
        check_eq("rst_overflow", WIDTH'(overflow), '0);
    endtask

    initial begin
        int p;
        int r;
        int k;
        logic [1:0] mv;
        logic rot;
        logic [WIDTH-1:0] nt;

        reset    = 1'b0;
        movement = 2'b00;
        new_top  = '0;
        rotate   = 1'b0;
        rot_addr = '0;
        model_reset();
        @(posedge clk);
        #1;

        // push/pop once
        do_reset();
        step(2'b01, 2, 0, 0);
        step(2'b01, 8, 0, 0);
        check_eq("s1_top", top, 8);
        check_eq("s1_second", second, 2);
        step(2'b10, 2, 0, 0);
        check_eq("s1_pop", top, 2);
        // pop twice
        step(2'b01, 11, 0, 0);
        step(2'b01, 12, 0, 0);
        step(2'b11, 2, 0, 0);
        check_eq("s2_pop2", top, 2);

        // rotate bring-to-top
        do_reset();
        step(2'b00, 2, 0, 0);
        step(2'b01, 33, 0, 0);
        step(2'b01, 57, 0, 0);
        step(2'b01, 77, 0, 0);
        step(2'b01, 79, 0, 0);
        step(2'b00, 57, 1, 1);
        check_eq("s3_rot_top", top, 57);
        check_eq("s3_rot_second", second, 79);
        step(2'b11, 77, 0, 0);
        check_eq("s3_pop2_top", top, 77);
        check_eq("s3_pop2_second", second, 33);

        // copy via push of rot_val
        do_reset();
        step(2'b00, 2, 0, 0);
        step(2'b01, 33, 0, 0);
        step(2'b01, 77, 0, 0);
        step(2'b01, 2, 0, 1);
        check_eq("s4_copy_top", top, 2);
        check_eq("s4_copy_second", second, 77);

        // arithmetic-style use
        do_reset();
        step(2'b00, 2, 0, 0);
        step(2'b01, 102, 0, 0);
        step(2'b01, 200, 0, 0);
        step(2'b10, 302, 0, 0);
        check_eq("s5_add_top", top, 302);
        check_eq("s5_add_second", second, 2);
        step(2'b01, 44, 0, 0);
        step(2'b01, 22, 0, 0);
        step(2'b11, 66, 0, 0);
        check_eq("s5_add2_top", top, 66);
        check_eq("s5_add2_second", second, 2);
        check_eq("s5_overflow", WIDTH'(overflow), '0);

        // fill to overflow and saturate
        do_reset();
        repeat (63) step(2'b01, 0, 0, 0);
        check_eq("ovf_63", WIDTH'(overflow), '0);
        step(2'b01, 0, 0, 0);
        check_eq("ovf_64", WIDTH'(overflow), 1);
        repeat (3) step(2'b01, $urandom, 0, 0);
        step(2'b10, $urandom, 0, 0);
        check_eq("ovf_sat_pop", WIDTH'(overflow), 1);
        step(2'b10, $urandom, 0, 0);
        check_eq("ovf_drop", WIDTH'(overflow), '0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                p = ((i / 300) % 2 == 0) ? 70 : 20;
                r = $urandom_range(0, 99);
                if (r < p) mv = 2'b01;
                else mv = 2'(r % 3 == 0 ? 0 : (r % 3 == 1 ? 2 : 3));
                if (mv == 2'b10 && m_cnt < 1) mv = 2'b00;
                if (mv == 2'b11 && m_cnt < 2) mv = 2'b00;
                rot = 1'($urandom);
                if (m_cnt > 0) begin
                    k = $urandom_range(0, (m_cnt < 64 ? m_cnt : 64) - 1);
                end else begin
                    k = $urandom_range(0, 63);
                    if (mv == 2'b00) rot = 1'b0;
                end
                if (rot_known(k) && $urandom_range(0, 3) == 0) begin
                    nt = m[k+1].d;
                end else begin
                    nt = $urandom;
                end
                step(mv, nt, rot, k);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dstack.md
DSTACK -- requirements
Module: dstack

Interface
REQ-001 Parameter WIDTH, default 32: data word width.
REQ-002 Parameter DEPTH, default 65: maximum number of stacked words, top included.
REQ-003 Parameter DEPTH_MAG, default 7: bit width of the internal occupancy counter; rot_addr width SHALL be DEPTH_MAG-1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 movement  input  2  stack motion: 00 none, 01 push once, 10 pop once, 11 pop twice.
REQ-007 new_top  input  WIDTH  value written to top on every non-reset edge.
REQ-008 rotate  input  1  remove the element at rot_addr and shift the elements above it down by one.
REQ-009 rot_addr  input  DEPTH_MAG-1  element index for rot_val and rotate; 0 = second, 1 = third, k = depth k+1 (top = depth 0).
REQ-010 rot_val  output  WIDTH  combinational read of the element selected by rot_addr.
REQ-011 top, second, third  output  WIDTH  elements at depth 0, 1 and 2.
REQ-012 overflow  output  1  high while occupancy >= DEPTH-1.

Function
REQ-013 Every non-reset edge SHALL load top with new_top; only the deeper elements move as selected by movement.
REQ-014 Push (01): depth d+1 SHALL take old depth d for all d; occupancy +1.
REQ-015 Pop once (10): depth d SHALL take old depth d+1 for d >= 1; occupancy -1.
REQ-016 Pop twice (11): depth d SHALL take old depth d+2 for d >= 1; occupancy -2.
REQ-017 None (00) with rotate=0: depths >= 1 SHALL hold their values.
REQ-018 Rotate applies only with movement=00: for k=rot_addr, depths 2..k+1 SHALL take old depths 1..k, depth 1 SHALL take old top, deeper elements SHALL hold, and occupancy is unchanged.
REQ-019 rotate with movement != 00 SHALL be ignored.
REQ-020 With new_top=rot_val, rotate brings the selected element to top. With rot_addr=0 this swaps top and second.
REQ-021 rot_val SHALL depend only on current state and rot_addr; it is used for copy (push with new_top=rot_val).
REQ-022 A push at occupancy DEPTH SHALL discard the deepest element; occupancy saturates at DEPTH.
REQ-023 A pop below empty SHALL saturate occupancy at 0; exposed data are undefined.
REQ-024 rot_val for an index at or beyond occupancy is undefined.
REQ-025 overflow SHALL be derived combinationally from the registered occupancy.

Reset
REQ-026 When reset is low at an edge: occupancy 0; top, second and third 0; overflow 0. Deeper storage contents are don't-care.
REQ-027 Reset SHALL override movement and rotate; reset may occur mid-sequence, and the stack is empty on the following cycle.

Structure
REQ-028 A shared package SHALL hold the movement encodings (S_NOTHING, S_PUSH_ONCE, S_POP_ONCE, S_POP_TWICE).
REQ-029 Storage SHALL be a DEPTH-entry register array with a per-entry next-value mux (hold, from d-1, from d+1, from d+2), plus a rot_addr read mux and an occupancy counter.
REQ-030 No sub-module is needed; a per-entry cell "dstack_cell" is optional.

Verification
REQ-031 Scenario: reset; push 2; push 8 -> top=8, second=2; pop once with new_top=second -> top=2.
REQ-032 Scenario: push 11, push 12; pop twice with new_top=third -> top=2.
REQ-033 Scenario: stack 2,33,57,77,79 (79 top); rotate, movement=00, rot_addr=1, new_top=rot_val -> top=57, second=79. Then pop twice with new_top=third -> top=77, second=33.
REQ-034 Scenario: stack 2,33,77; push with rot_addr=1, new_top=rot_val -> top=2, second=77.
REQ-035 Scenario: push 102, push 200; pop once with new_top=top+second -> top=302, second=2. Push 44, push 22; pop twice with new_top=top+second -> top=66, second=2, overflow=0.
REQ-036 Scenario: reset; 64 pushes of 0 -> overflow=1. Reset -> overflow=0 and top, second, third all 0.
